// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter
// Registered bus-source arbiter between the control unit and the 32-bit bus
// multiplexer. Picks one of NUM_SRC drive requests, using either fixed priority
// (lowest index wins) or round-robin. Outputs a registered mux select, a one-hot
// grant, a valid flag and multi-driver conflict flags.
// Optional build macro: ARB_CONFLICT_COUNT_EN adds a saturating 8-bit
// conflict_count output.
module bus_source_arbiter #(
   parameter int NUM_SRC    = 24,
   parameter int SEL_W      = 5,
   parameter int RR_DEFAULT = 0
) (
   input  logic               clock,
   input  logic               clear,
   input  logic [NUM_SRC-1:0] req,
   input  logic               mode_wr,
   input  logic               mode_in,
   input  logic               conflict_clr,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   output logic [NUM_SRC-1:0] grant,
   output logic               conflict,
   output logic               conflict_sticky
`ifdef ARB_CONFLICT_COUNT_EN
   ,
   output logic [7:0]         conflict_count
`endif
);

   typedef enum logic {
      MODE_PRIO = 1'b0,
      MODE_RR   = 1'b1
   } arb_mode_e;

   arb_mode_e           r_mode;
   logic [SEL_W-1:0]    r_rr_ptr;
   logic [SEL_W-1:0]    r_sel;
   logic                r_valid;
   logic [NUM_SRC-1:0]  r_grant;
   logic                r_conflict;
   logic                r_sticky;

   logic [SEL_W-1:0]    w_win_idx;
   logic                w_any;
   logic                w_conflict;
   logic [NUM_SRC-1:0]  w_grant;
   int                  w_idx;

   // Pick the winning index for this cycle's req under the current mode.
   // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
   always_comb begin
      w_win_idx  = '0;
      w_idx      = 0;
      w_any      = |req;
      w_conflict = ($countones(req) > 1);
      if (r_mode == MODE_PRIO) begin
         // Descending scan: the last hit, which is the lowest set index, wins.
         for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) w_win_idx = SEL_W'(i);
         end
      end else begin
         // Descending offset from rr_ptr: the last hit, which is the nearest
         // index at or after rr_ptr (with wrap), wins.
         for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
            if (req[w_idx]) w_win_idx = SEL_W'(w_idx);
         end
      end
      w_grant = w_any ? (NUM_SRC'(1) << w_win_idx) : '0;
   end

   // Register the arbitration result, the conflict flags, the mode and the rotation pointer.
   // NOTE: state is updated only with non-blocking assignments, so every register samples pre-edge values.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_sel      <= '0;
         r_valid    <= 1'b0;
         r_grant    <= '0;
         r_conflict <= 1'b0;
         r_sticky   <= 1'b0;
         r_rr_ptr   <= '0;
         r_mode     <= arb_mode_e'(RR_DEFAULT[0]);
      end else begin
         r_valid    <= w_any;
         r_grant    <= w_grant;
         r_conflict <= w_conflict;
         // Keep sel stable on idle cycles so the bus mux does not glitch.
         if (w_any) r_sel <= w_win_idx;
         // A new conflict takes precedence over a clear in the same cycle.
         if (w_conflict)        r_sticky <= 1'b1;
         else if (conflict_clr) r_sticky <= 1'b0;
         if (mode_wr) begin
            r_mode   <= arb_mode_e'(mode_in);
            r_rr_ptr <= '0;
         end else if (r_mode == MODE_RR && w_any) begin
            r_rr_ptr <= (w_win_idx == SEL_W'(NUM_SRC - 1)) ? '0 : w_win_idx + SEL_W'(1);
         end
      end
   end

   assign sel             = r_sel;
   assign sel_valid       = r_valid;
   assign grant           = r_grant;
   assign conflict        = r_conflict;
   assign conflict_sticky = r_sticky;

`ifdef ARB_CONFLICT_COUNT_EN
   logic [7:0] r_conflict_count;

   // Count conflict cycles, saturating at 255. An increment beats conflict_clr.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_conflict_count <= '0;
      end else if (w_conflict) begin
         if (conflict_clr)                r_conflict_count <= 8'd1;
         else if (r_conflict_count != '1) r_conflict_count <= r_conflict_count + 8'd1;
      end else if (conflict_clr) begin
         r_conflict_count <= '0;
      end
   end

   assign conflict_count = r_conflict_count;
`endif

endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb_bus_source_arbiter
// Directed test of bus_source_arbiter: reset, priority, conflict flags,
// round-robin wrap, mode switching and asynchronous clear. Define
// ARB_CONFLICT_COUNT_EN to also exercise the saturating conflict counter.
module tb_bus_source_arbiter;

   localparam int NUM_SRC = 24;
   localparam int SEL_W   = 5;

   logic               clock = 1'b0;
   logic               clear;
   logic [NUM_SRC-1:0] req;
   logic               mode_wr;
   logic               mode_in;
   logic               conflict_clr;
   logic [SEL_W-1:0]   sel;
   logic               sel_valid;
   logic [NUM_SRC-1:0] grant;
   logic               conflict;
   logic               conflict_sticky;
`ifdef ARB_CONFLICT_COUNT_EN
   logic [7:0]         conflict_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   bus_source_arbiter #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .RR_DEFAULT(0)) dut (
      .clock           (clock),
      .clear           (clear),
      .req             (req),
      .mode_wr         (mode_wr),
      .mode_in         (mode_in),
      .conflict_clr    (conflict_clr),
      .sel             (sel),
      .sel_valid       (sel_valid),
      .grant           (grant),
      .conflict        (conflict),
      .conflict_sticky (conflict_sticky)
`ifdef ARB_CONFLICT_COUNT_EN
      ,
      .conflict_count  (conflict_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_tests++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clock edge, then settle 1 time unit so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [SEL_W-1:0] e_sel, input logic e_valid,
                            input logic [NUM_SRC-1:0] e_grant);
      check({tag, ".sel"},   32'(sel),       32'(e_sel));
      check({tag, ".valid"}, 32'(sel_valid), 32'(e_valid));
      check({tag, ".grant"}, 32'(grant),     32'(e_grant));
   endtask

   initial begin
      clear        = 1'b1;
      req          = 24'hFFFFFF;
      mode_wr      = 1'b0;
      mode_in      = 1'b0;
      conflict_clr = 1'b0;

      // Reset holds everything at zero even with every request set.
      #12;
      check_out("rst", 5'd0, 1'b0, 24'h0);
      check("rst.conflict", 32'(conflict), 32'd0);
      check("rst.sticky", 32'(conflict_sticky), 32'd0);

      clear = 1'b0;
      req   = '0;
      step();
      check_out("idle", 5'd0, 1'b0, 24'h0);
      check("idle.conflict", 32'(conflict), 32'd0);

      // Priority, single request: HIout.
      req = 24'h010000;
      step();
      check_out("hi", 5'd16, 1'b1, 24'h010000);
      check("hi.conflict", 32'(conflict), 32'd0);
      req = '0;
      step();
      check_out("hi_hold", 5'd16, 1'b0, 24'h0);

      // Priority conflict: R2 and R5, lowest wins.
      req = 24'h000024;
      step();
      check_out("pc", 5'd2, 1'b1, 24'h000004);
      check("pc.conflict", 32'(conflict), 32'd1);
      check("pc.sticky", 32'(conflict_sticky), 32'd1);
      req = 24'h000020;
      step();
      check_out("p5", 5'd5, 1'b1, 24'h000020);
      check("p5.conflict", 32'(conflict), 32'd0);
      check("p5.sticky", 32'(conflict_sticky), 32'd1);
      // Clear strobe together with a new conflict: set wins.
      conflict_clr = 1'b1;
      req = 24'h000003;
      step();
      check_out("pclr", 5'd0, 1'b1, 24'h000001);
      check("pclr.conflict", 32'(conflict), 32'd1);
      check("pclr.sticky", 32'(conflict_sticky), 32'd1);
      // Clear strobe without a conflict does clear.
      req = '0;
      step();
      check("clr.sticky", 32'(conflict_sticky), 32'd0);
      check_out("clr", 5'd0, 1'b0, 24'h0);
      conflict_clr = 1'b0;

      // Round-robin wrap with R0 and Cout held.
      mode_wr = 1'b1;
      mode_in = 1'b1;
      req     = 24'h800001;
      step();
      check_out("rr_wr", 5'd0, 1'b1, 24'h000001);
      mode_wr = 1'b0;
      step();
      check_out("rr0", 5'd0, 1'b1, 24'h000001);
      step();
      check_out("rr1", 5'd23, 1'b1, 24'h800000);
      step();
      check_out("rr2", 5'd0, 1'b1, 24'h000001);
      check("rr2.conflict", 32'(conflict), 32'd1);
      step();
      check_out("rr3", 5'd23, 1'b1, 24'h800000);

      // Round-robin skips past idle requests: pointer is 0, only R5 set.
      req = 24'h000020;
      step();
      check_out("rr5", 5'd5, 1'b1, 24'h000020);
      // Switch to priority; this edge still arbitrates in round-robin from ptr 6 (wraps to 0).
      mode_wr = 1'b1;
      mode_in = 1'b0;
      req     = 24'h000021;
      step();
      check_out("ms0", 5'd0, 1'b1, 24'h000001);
      mode_wr = 1'b0;
      step();
      check_out("ms1", 5'd0, 1'b1, 24'h000001);
      step();
      check_out("ms2", 5'd0, 1'b1, 24'h000001);
      // Back to round-robin; pointer restarts at 0.
      mode_wr = 1'b1;
      mode_in = 1'b1;
      step();
      check_out("ms3", 5'd0, 1'b1, 24'h000001);
      mode_wr = 1'b0;
      step();
      check_out("ms4", 5'd0, 1'b1, 24'h000001);
      step();
      check_out("ms5", 5'd5, 1'b1, 24'h000020);
      step();
      check_out("ms6", 5'd0, 1'b1, 24'h000001);

      // Async clear between edges while sel = 23.
      req = 24'h800000;
      step();
      check_out("pre_clr", 5'd23, 1'b1, 24'h800000);
      #2;
      clear = 1'b1;
      #1;
      check_out("aclr", 5'd0, 1'b0, 24'h0);
      check("aclr.sticky", 32'(conflict_sticky), 32'd0);
      check("aclr.conflict", 32'(conflict), 32'd0);
      #3;
      clear = 1'b0;
      // Mode returned to priority: repeated R0+R5 always grants R0.
      req = 24'h000021;
      step();
      check_out("post0", 5'd0, 1'b1, 24'h000001);
      step();
      check_out("post1", 5'd0, 1'b1, 24'h000001);

`ifdef ARB_CONFLICT_COUNT_EN
      // Saturating conflict counter.
      clear = 1'b1;
      #1;
      check("cnt.rst", 32'(conflict_count), 32'd0);
      clear = 1'b0;
      req   = 24'h000003;
      for (int i = 0; i < 300; i++) step();
      check("cnt.sat", 32'(conflict_count), 32'd255);
      conflict_clr = 1'b1;
      step();
      check("cnt.clr_inc", 32'(conflict_count), 32'd1);
      req = 24'h000001;
      step();
      check("cnt.clr", 32'(conflict_count), 32'd0);
      conflict_clr = 1'b0;
`endif

      req = '0;
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Registered, parametrised successor to the datapath bus-source encoder.
- Takes NUM_SRC one-hot-intended source-drive requests (R0out..R15out, HIout, LOout, ZHIout, ZLOout, PCout, MDRout, InPortout, Cout at the default ordering) and produces a registered bus-mux select.
- Adds fixed-priority or round-robin arbitration, a one-hot grant, valid tracking and multi-driver conflict detection.
- Sits between the control unit and the 32-bit bus multiplexer.

Parameters:
- NUM_SRC, 24, number of bus sources; bit i of req maps to mux input i.
- SEL_W, 5, select width; must satisfy 2**SEL_W >= NUM_SRC.
- RR_DEFAULT, 0, value of the internal mode register after reset: 0 = fixed priority, 1 = round-robin.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- req  in  NUM_SRC  source-drive requests, bit 0 = R0out.
- mode_wr  in  1  write strobe for the mode register.
- mode_in  in  1  new mode value: 0 = priority, 1 = round-robin.
- conflict_clr  in  1  clears conflict_sticky.
- sel  out  SEL_W  registered mux select.
- sel_valid  out  1  high when sel reflects a request from the previous cycle.
- grant  out  NUM_SRC  registered one-hot grant.
- conflict  out  1  previous-cycle req had two or more bits set.
- conflict_sticky  out  1  latched conflict flag.

Behaviour:
- Reset (clear=1, async): sel=0, sel_valid=0, grant=0, conflict=0, conflict_sticky=0, rr_ptr=0, mode=RR_DEFAULT.
- Latency: one cycle. req sampled at rising edge N appears on outputs after edge N.
- Any req bit set:
  - grant gets exactly one bit; sel = its index; sel_valid=1.
- req all zero:
  - sel_valid=0, grant=0.
  - sel holds its last value so the mux stays stable.
- Priority mode: lowest set index wins (R0 highest).
- Round-robin mode:
  - Search starts at rr_ptr and ascends, wrapping from NUM_SRC-1 to 0.
  - After a grant to index g, rr_ptr = g+1, or 0 when g = NUM_SRC-1.
  - rr_ptr does not change in cycles with no grant.
- rr_ptr does not change in priority mode.
- mode_wr:
  - Updates the mode register at the edge; the new mode applies from the next sampled req.
  - rr_ptr resets to 0 on any mode_wr.
- Indices >= NUM_SRC are never granted. Unused upper sel codes are never produced.
- conflict = 1 when popcount(req) >= 2; arbitration still grants one source.
- conflict_sticky:
  - Sets when conflict is detected; cleared by conflict_clr.
  - Simultaneous conflict_clr and new conflict: set wins, sticky stays 1.
- clear asserted mid-stream: all outputs return to reset values immediately, with no wait for a clock edge.
- No combinational path from req to any output.

Optional Feature:
- Macro ARB_CONFLICT_COUNT_EN.
- Defined:
  - Adds output conflict_count (8 bits), incremented on every cycle with conflict=1.
  - Saturates at 255.
  - Cleared by clear and by conflict_clr; increment wins over conflict_clr in the same cycle (count becomes 1).
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: clear=1 with req=0xFFFFFF -> sel=0, sel_valid=0, grant=0, conflict=0; release clear, req=0 -> outputs remain 0.
- Priority single: req=bit16 (HIout) -> next cycle sel=16, grant=0x010000, sel_valid=1; then req=0 -> sel_valid=0, sel holds 16.
- Priority conflict: req=0x000024 (R2, R5) -> sel=2, conflict=1, conflict_sticky=1. Then req=0x000020 -> sel=5, conflict=0, sticky still 1. Then conflict_clr with req=0x000003 -> sticky stays 1 (set wins).
- Round-robin wrap:
  - Setup: mode_wr=1, mode_in=1; req held at 0x800001 (R0, Cout).
  - Expected grants on successive cycles: 0, 23, 0, 23; rr_ptr wraps to 0 after 23.
- Mode switch: in round-robin after a grant to 5, write mode=0 with req=0x000021 -> next grant 0 (priority); write mode=1 -> rr_ptr=0, grant 0.
- Async clear mid-stream: assert clear between edges while sel=23 -> sel=0 and sel_valid=0 before the next edge. With ARB_CONFLICT_COUNT_EN, 300 conflict cycles -> conflict_count=255.
